// File: rtl/regfile_access_arbiter_if.sv
// Debug-host request/response channel into the register-file access arbiter.
// The master modport is the debug host and the slave modport is the arbiter.
interface regfile_access_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Arbitrates the PICO_MIPS register-file write port between CPU write-back and a debug host.
// CPU write-back has priority, and a starvation counter stalls the CPU for one cycle so a waiting debug write can land.
module regfile_access_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cpu_we,
    input  logic [ADDR_W-1:0]         i_cpu_waddr,
    input  logic [DATA_W-1:0]         i_cpu_wdata,
    output logic                      o_cpu_stall,
    regfile_access_arbiter_if.slave   dbg,
    output logic                      o_rf_we,
    output logic [ADDR_W-1:0]         o_rf_waddr,
    output logic [DATA_W-1:0]         o_rf_wdata,
    output logic [ADDR_W-1:0]         o_rf_raddr,
    input  logic [DATA_W-1:0]         i_rf_rdata
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_starve_cnt, w_cnt_next;
    logic               r_cpu_stall;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               w_accept;
    logic               w_dbg_wr;
    logic [DATA_W-1:0]  w_capture;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_cpu_stall  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_state      <= w_next;
            r_starve_cnt <= w_cnt_next;
            r_cpu_stall  <= (w_next == S_STALL);
            r_rsp_valid  <= w_accept;
            if (w_accept)
                r_rsp_rdata <= w_capture;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_starve_cnt;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!dbg.req_valid) begin
                    w_cnt_next = '0;
                end else if (!dbg.req_write || !i_cpu_we) begin
                    w_accept   = 1'b1;
                    w_cnt_next = '0;
                    w_next     = S_RESP;
                end else begin
                    // Denied debug write: the CPU keeps the port this cycle.
                    w_cnt_next = r_starve_cnt + 1'b1;
                    if (r_starve_cnt == CNT_W'(STARVE_MAX - 1))
                        w_next = S_STALL;
                end
            end
            S_STALL: begin
                if (dbg.req_valid) begin
                    w_accept   = 1'b1;
                    w_cnt_next = '0;
                    w_next     = S_RESP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_rst)
            w_accept = 1'b0;
    end

    assign w_dbg_wr = w_accept && dbg.req_write;

    // Reads see a same-cycle CPU write to the same index, not the stale file contents.
    assign w_capture = dbg.req_write ? dbg.req_wdata :
                       (i_cpu_we && (i_cpu_waddr == dbg.req_addr)) ? i_cpu_wdata : i_rf_rdata;

    assign o_rf_we    = w_dbg_wr || (i_cpu_we && (r_state != S_STALL) && !i_rst);
    assign o_rf_waddr = w_dbg_wr ? dbg.req_addr  : i_cpu_waddr;
    assign o_rf_wdata = w_dbg_wr ? dbg.req_wdata : i_cpu_wdata;
    assign o_rf_raddr = dbg.req_addr;

    assign dbg.req_ready = w_accept;
    assign dbg.rsp_valid = r_rsp_valid;
    assign dbg.rsp_rdata = r_rsp_rdata;
    assign o_cpu_stall   = r_cpu_stall;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_regfile_access_arbiter;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_we;
    logic [AW-1:0] cpu_waddr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr, rf_raddr;
    logic [DW-1:0] rf_wdata, rf_rdata;

    always #5 clk = ~clk;

    regfile_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) dbg ();

    regfile_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_we(cpu_we), .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_stall(cpu_stall), .dbg(dbg.slave),
        .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: denied-write streak, stall cycle pending, response pending.
    int            m_deny = 0;
    bit            m_stall = 0, m_rsp = 0;
    logic [DW-1:0] m_data = '0;

    // DUT values sampled mid-cycle by the last cyc call.
    bit            s_acc;
    logic          s_ready, s_rfwe, s_stall;
    logic [AW-1:0] s_waddr;
    logic [DW-1:0] s_wdata;

    // Called 1ns after a rising edge with inputs applied; checks, then advances one cycle.
    task automatic cyc;
        bit            e_ready, e_we, idle;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd, cap;
        #3;
        e_ready = !rst && !m_rsp && dbg.req_valid &&
                  (m_stall || !dbg.req_write || !cpu_we);
        if (rst) begin
            e_we = 0; e_wa = cpu_waddr; e_wd = cpu_wdata;
        end else if (e_ready && dbg.req_write) begin
            e_we = 1; e_wa = dbg.req_addr; e_wd = dbg.req_wdata;
        end else begin
            e_we = cpu_we && !m_stall; e_wa = cpu_waddr; e_wd = cpu_wdata;
        end
        chk("ready", dbg.req_ready, e_ready);
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_waddr", rf_waddr, e_wa);
            chk("rf_wdata", rf_wdata, e_wd);
        end
        chk("rf_raddr", rf_raddr, dbg.req_addr);
        chk("cpu_stall", cpu_stall, m_stall);
        chk("rsp_valid", dbg.rsp_valid, m_rsp);
        if (m_rsp) chk("rsp_rdata", dbg.rsp_rdata, m_data);
        cap = dbg.req_write ? dbg.req_wdata :
              (cpu_we && cpu_waddr == dbg.req_addr) ? cpu_wdata : rf_rdata;
        s_acc = e_ready; s_ready = dbg.req_ready; s_rfwe = rf_we;
        s_waddr = rf_waddr; s_wdata = rf_wdata; s_stall = cpu_stall;
        @(posedge clk);
        if (rst) begin
            m_deny = 0; m_stall = 0; m_rsp = 0; m_data = '0;
        end else begin
            idle = !m_rsp && !m_stall;
            if (e_ready) begin
                m_deny = 0; m_stall = 0; m_rsp = 1; m_data = cap;
            end else begin
                m_rsp = 0;
                if (m_stall) m_stall = 0;
                else if (idle && dbg.req_valid && dbg.req_write && cpu_we) begin
                    m_deny++;
                    if (m_deny == SM) m_stall = 1;
                end else if (idle && !dbg.req_valid) m_deny = 0;
            end
        end
        #1;
    endtask

    task automatic req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg.req_valid = 1; dbg.req_write = wr; dbg.req_addr = a; dbg.req_wdata = d;
    endtask

    bit h_active = 0;

    initial begin
        rst = 1; cpu_we = 0; cpu_waddr = '0; cpu_wdata = '0; rf_rdata = '0;
        dbg.req_valid = 0; dbg.req_write = 0; dbg.req_addr = '0; dbg.req_wdata = '0;
        @(posedge clk); #1;

        // Reset held with a pending debug write and CPU activity.
        req(1, 5'd2, 8'h12); cpu_we = 1;
        for (int i = 0; i < 3; i++) begin
            cyc;
            chk("t1_ready", s_ready, 0);
            chk("t1_rf_we", s_rfwe, 0);
            chk("t1_stall", cpu_stall, 0);
            chk("t1_rsp", dbg.rsp_valid, 0);
        end
        rst = 0; cpu_we = 0; dbg.req_valid = 0; cyc;

        // Plain read.
        req(0, 5'd5, 8'h00); rf_rdata = 8'h3C; cyc;
        chk("t2_ready_T", s_ready, 1);
        chk("t2_rsp", dbg.rsp_valid, 1);
        chk("t2_rdata", dbg.rsp_rdata, 8'h3C);
        chk("t2_ready_T1", dbg.req_ready, 0);
        dbg.req_valid = 0; cyc;

        // Read forwarded from a same-index CPU write.
        req(0, 5'd7, 8'h00); cpu_we = 1; cpu_waddr = 5'd7; cpu_wdata = 8'hA5; rf_rdata = 8'h11; cyc;
        chk("t3_fwd", dbg.rsp_rdata, 8'hA5);
        dbg.req_valid = 0; cpu_we = 0; cyc;

        // Uncontended write.
        req(1, 5'd3, 8'h55); cyc;
        chk("t4_rf_we", s_rfwe, 1);
        chk("t4_waddr", s_waddr, 5'd3);
        chk("t4_wdata", s_wdata, 8'h55);
        chk("t4_rsp", dbg.rsp_valid, 1);
        chk("t4_rdata", dbg.rsp_rdata, 8'h55);
        dbg.req_valid = 0; cyc;

        // Starvation forces one stall cycle.
        req(1, 5'd9, 8'h77); cpu_we = 1; cpu_waddr = 5'd1; cpu_wdata = 8'h22;
        for (int i = 0; i < SM; i++) begin
            cyc;
            chk("t5_denied", s_ready, 0);
            chk("t5_cpu_wr", s_waddr, 5'd1);
        end
        cyc;
        chk("t5_stall", s_stall, 1);
        chk("t5_ready", s_ready, 1);
        chk("t5_waddr", s_waddr, 5'd9);
        chk("t5_wdata", s_wdata, 8'h77);
        chk("t5_rsp", dbg.rsp_valid, 1);
        chk("t5_unstall", cpu_stall, 0);
        dbg.req_valid = 0; cpu_we = 0; cyc;

        // Reset during the response cycle drops the response.
        req(0, 5'd4, 8'h00); rf_rdata = 8'h99; cyc;
        dbg.req_valid = 0; rst = 1; cyc;
        rst = 0;
        chk("t6_rsp", dbg.rsp_valid, 0);
        chk("t6_stall", cpu_stall, 0);
        // Starvation count must restart from zero after reset.
        req(1, 5'd6, 8'h44); cpu_we = 1;
        for (int i = 0; i < SM - 1; i++) cyc;
        chk("t6_cnt", cpu_stall, 0);
        cyc;
        dbg.req_valid = 0; cpu_we = 0; cyc;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!h_active && $urandom_range(0, 2) != 0) begin
                h_active = 1;
                req($urandom_range(0, 1) != 0, AW'($urandom), DW'($urandom));
            end
            dbg.req_valid = h_active;
            cpu_we    = ($urandom_range(0, 3) != 0);
            cpu_waddr = ($urandom_range(0, 2) == 0) ? dbg.req_addr : AW'($urandom);
            cpu_wdata = DW'($urandom);
            rf_rdata  = DW'($urandom);
            cyc;
            if (s_acc || rst) h_active = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
